// File: rtl/ahb_sram_ws_if.sv
// AHB-Lite bus bundle for the SRAM slave.
// The master modport is the bus side; the slave modport is the memory side.
interface ahb_sram_ws_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hreadyin, hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyin,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with byte/halfword strobes, separate NONSEQ/SEQ wait
// states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_ws #(
  parameter int MEM_DEPTH       = 1024,
  parameter int WIN_BITS        = 16,
  parameter int WAIT_STATES     = 0,
  parameter int SEQ_WAIT_STATES = 0
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_sram_ws_if.slave bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] NSEQ_WS = 3'(WAIT_STATES);
  localparam logic [2:0] SEQ_WS  = 3'(SEQ_WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t r_state, w_next;
  logic [2:0]    r_cnt, w_cntNext;
  logic          r_write;
  logic [3:0]    r_lanes;
  logic [AW-1:0] r_idx;

  logic [31:0] r_mem [0:MEM_DEPTH-1];

  logic          w_accept;
  logic [WIN_BITS-1:0] w_offset;
  logic          w_illegal;
  logic [2:0]    w_waitN;
  logic [3:0]    w_lanes;
  logic          w_unused;

  assign w_accept = bus.hsel & bus.hreadyin & bus.htrans[1];
  assign w_offset = bus.haddr[WIN_BITS-1:0];
  assign w_waitN  = bus.htrans[0] ? SEQ_WS : NSEQ_WS;
  assign w_unused = ^{bus.hburst, bus.haddr[31:WIN_BITS]};

  assign w_illegal = (bus.hsize > 3'd2)
                   | ((bus.hsize == 3'd1) & bus.haddr[0])
                   | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00))
                   | (32'(w_offset) >= 32'(MEM_DEPTH * 4));

  always_comb begin
    w_lanes = 4'b0000;
    case (bus.hsize)
      3'd0:    w_lanes[bus.haddr[1:0]] = 1'b1;
      3'd1:    w_lanes = bus.haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_lanes = 4'b1111;
      default: w_lanes = 4'b0000;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_write <= 1'b0;
      r_lanes <= 4'b0000;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cntNext;
      if (w_accept) begin
        r_write <= bus.hwrite;
        r_lanes <= w_lanes;
        r_idx   <= bus.haddr[AW+1:2];
      end
    end
  end

  // Accepts are only honoured in states where hreadyout is high.
  always_comb begin
    w_next    = r_state;
    w_cntNext = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 3'd0) w_next = S_DATA;
        else               w_cntNext = r_cnt - 3'd1;
      end
      S_ERR1: w_next = S_ERR2;
      default: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_next = S_ERR1;
          end else if (w_waitN != 3'd0) begin
            w_next    = S_WAIT;
            w_cntNext = w_waitN - 3'd1;
          end else begin
            w_next = S_DATA;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
    endcase
  end

  // Error transfers never reach DATA, so they can neither write nor return data.
  always_ff @(posedge hclk) begin
    if (r_state == S_DATA && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_lanes[i]) r_mem[r_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hrdata    = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : 32'd0;
  assign bus.hreadyout = !(r_state == S_WAIT || r_state == S_ERR1);
  assign bus.hresp     = (r_state == S_ERR1 || r_state == S_ERR2) ? 2'b01 : 2'b00;

endmodule
